// File: rtl/mipi_dsi_pkg.sv
// Shared types, DSI data-type constants and header/CRC helper functions
// for the DSI packet parser.
package mipi_dsi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WC_W   = 16;
    localparam int unsigned CRC_W  = 16;
    localparam int unsigned ECC_W  = 6;
    localparam int unsigned DT_W   = 6;
    localparam int unsigned HCNT_W = 2;

    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    localparam logic [DT_W-1:0] DT_DCS_SHORT_WR = 6'h05;
    localparam logic [DT_W-1:0] DT_DCS_LONG_WR  = 6'h39;
    localparam logic [DT_W-1:0] DT_RGB888       = 6'h3E;
    localparam logic [DT_W-1:0] DT_NULL         = 6'h09;
    localparam logic [DT_W-1:0] DT_HSYNC_START  = 6'h21;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CRC     = 2'd3
    } dsi_state_t;

    // Header bytes as they sit in the 24-bit ECC input word
    typedef struct packed {
        logic [BYTE_W-1:0] wc_h;
        logic [BYTE_W-1:0] wc_l;
        logic [BYTE_W-1:0] di;
    } dsi_hdr_t;

    function automatic logic dsi_is_long(input logic [DT_W-1:0] dt);
        return (dt[3:0] == 4'h9) || (dt[3:0] == 4'hC) || (dt[3:0] == 4'hD) ||
               (dt[3:0] == 4'hE) || (dt == 6'h0B);
    endfunction

    function automatic logic [ECC_W-1:0] dsi_ecc(input logic [23:0] d);
        logic [ECC_W-1:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    // Byte-parallel form of the reflected 0x8408 CRC-16 (LSB first)
    function automatic logic [CRC_W-1:0] dsi_crc16_byte(input logic [CRC_W-1:0] crc,
                                                        input logic [BYTE_W-1:0] data);
        logic [BYTE_W-1:0] x;
        x = crc[7:0] ^ data;
        x = x ^ (x << 4);
        return {x, crc[15:8]} ^ {5'b0, x, 3'b0} ^ {12'b0, x[7:4]};
    endfunction

endpackage

// File: rtl/mipi_dsi_packet_parser_crc16.sv
// Byte-serial CRC-16 accumulator with clear/enable; only present when
// DSI_CRC_CHECK_EN is defined.
`ifdef DSI_CRC_CHECK_EN
module mipi_dsi_crc16
    import mipi_dsi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] data,
    output logic [CRC_W-1:0]  crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= dsi_crc16_byte(crc, data);
        end
    end

endmodule
`endif

// File: rtl/mipi_dsi_packet_parser.sv
// DSI single-lane packet parser: sync hunt, header/ECC decode, payload and CRC.
// Define DSI_CRC_CHECK_EN to check the payload CRC; otherwise crc_err stays 0.
module mipi_dsi_packet_parser
    import mipi_dsi_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hB8
)
(
    input  logic              byte_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              hdr_valid,
    output logic [BYTE_W-1:0] hdr_di,
    output logic [WC_W-1:0]   hdr_wc,
    output logic              hdr_long,
    output logic              hdr_ecc_err,
    output logic              pl_valid,
    output logic [BYTE_W-1:0] pl_data,
    output logic              pl_last,
    output logic              pkt_done,
    output logic              crc_err,
    output logic              trunc_err
);

    dsi_state_t        state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    dsi_hdr_t          hdr_q, hdr_d;
    logic [WC_W-1:0]   wc_cnt_q, wc_cnt_d;
    logic              crc_cnt_q, crc_cnt_d;

    logic              hdr_valid_d, hdr_long_d, hdr_ecc_err_d;
    logic [BYTE_W-1:0] hdr_di_d, pl_data_d;
    logic [WC_W-1:0]   hdr_wc_d;
    logic              pl_valid_d, pl_last_d, pkt_done_d, crc_err_d, trunc_err_d;

    logic [WC_W-1:0]   wc_c;
    logic              long_c;
    logic [ECC_W-1:0]  ecc_c;
    logic              crc_mismatch_c;

`ifdef DSI_CRC_CHECK_EN
    logic              crc_clr_c, crc_en_c;
    logic [BYTE_W-1:0] crc_lo_q;
    logic [CRC_W-1:0]  crc_val;

    // Restart on each header's ECC byte so WC=0 compares against the init value
    always_comb begin
        crc_clr_c = (state_q == ST_HDR) && in_valid && (hcnt_q == 2'd3);
        crc_en_c  = (state_q == ST_PAYLOAD) && in_valid;
    end

    mipi_dsi_crc16 u_crc16 (
        .clk  (byte_clk),
        .rst  (sys_rst),
        .clr  (crc_clr_c),
        .en   (crc_en_c),
        .data (in_data),
        .crc  (crc_val)
    );

    always_ff @(posedge byte_clk) begin
        if (sys_rst) begin
            crc_lo_q <= '0;
        end else if ((state_q == ST_CRC) && in_valid && !crc_cnt_q) begin
            crc_lo_q <= in_data;
        end
    end

    assign crc_mismatch_c = (crc_val != {in_data, crc_lo_q});
`else
    assign crc_mismatch_c = 1'b0;
`endif

    assign wc_c   = {hdr_q.wc_h, hdr_q.wc_l};
    assign long_c = dsi_is_long(hdr_q.di[DT_W-1:0]);
    assign ecc_c  = dsi_ecc(hdr_q);

    always_ff @(posedge byte_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            hcnt_q      <= '0;
            hdr_q       <= '0;
            wc_cnt_q    <= '0;
            crc_cnt_q   <= 1'b0;
            hdr_valid   <= 1'b0;
            hdr_di      <= '0;
            hdr_wc      <= '0;
            hdr_long    <= 1'b0;
            hdr_ecc_err <= 1'b0;
            pl_valid    <= 1'b0;
            pl_data     <= '0;
            pl_last     <= 1'b0;
            pkt_done    <= 1'b0;
            crc_err     <= 1'b0;
            trunc_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            hdr_q       <= hdr_d;
            wc_cnt_q    <= wc_cnt_d;
            crc_cnt_q   <= crc_cnt_d;
            hdr_valid   <= hdr_valid_d;
            hdr_di      <= hdr_di_d;
            hdr_wc      <= hdr_wc_d;
            hdr_long    <= hdr_long_d;
            hdr_ecc_err <= hdr_ecc_err_d;
            pl_valid    <= pl_valid_d;
            pl_data     <= pl_data_d;
            pl_last     <= pl_last_d;
            pkt_done    <= pkt_done_d;
            crc_err     <= crc_err_d;
            trunc_err   <= trunc_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        hdr_d         = hdr_q;
        wc_cnt_d      = wc_cnt_q;
        crc_cnt_d     = crc_cnt_q;
        hdr_valid_d   = 1'b0;
        pl_valid_d    = 1'b0;
        pl_last_d     = 1'b0;
        pkt_done_d    = 1'b0;
        trunc_err_d   = 1'b0;
        hdr_di_d      = hdr_di;
        hdr_wc_d      = hdr_wc;
        hdr_long_d    = hdr_long;
        hdr_ecc_err_d = hdr_ecc_err;
        pl_data_d     = pl_data;
        crc_err_d     = crc_err;

        if (!in_valid) begin
            // Burst end: only a header boundary counts as a clean stop
            if (state_q != ST_IDLE) begin
                trunc_err_d = (state_q != ST_HDR) || (hcnt_q != 2'd0);
                state_d     = ST_IDLE;
                hcnt_d      = '0;
                wc_cnt_d    = '0;
                crc_cnt_d   = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d = ST_HDR;
                        hcnt_d  = '0;
                    end
                end
                ST_HDR: begin
                    hcnt_d = hcnt_q + 2'd1;
                    case (hcnt_q)
                        2'd0:    hdr_d.di   = in_data;
                        2'd1:    hdr_d.wc_l = in_data;
                        2'd2:    hdr_d.wc_h = in_data;
                        default: begin
                            hdr_valid_d   = 1'b1;
                            hdr_di_d      = hdr_q.di;
                            hdr_wc_d      = wc_c;
                            hdr_long_d    = long_c;
                            hdr_ecc_err_d = (in_data != {2'b00, ecc_c});
                            if (!long_c) begin
                                pkt_done_d = 1'b1;
                                crc_err_d  = 1'b0;
                            end else if (wc_c == '0) begin
                                state_d   = ST_CRC;
                                crc_cnt_d = 1'b0;
                            end else begin
                                state_d  = ST_PAYLOAD;
                                wc_cnt_d = wc_c;
                            end
                        end
                    endcase
                end
                ST_PAYLOAD: begin
                    pl_valid_d = 1'b1;
                    pl_data_d  = in_data;
                    pl_last_d  = (wc_cnt_q == 16'd1);
                    wc_cnt_d   = wc_cnt_q - 16'd1;
                    if (wc_cnt_q == 16'd1) begin
                        state_d   = ST_CRC;
                        crc_cnt_d = 1'b0;
                    end
                end
                ST_CRC: begin
                    crc_cnt_d = 1'b1;
                    if (crc_cnt_q) begin
                        pkt_done_d = 1'b1;
                        crc_err_d  = crc_mismatch_c;
                        state_d    = ST_HDR;
                        hcnt_d     = '0;
                        crc_cnt_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_dsi_packet_parser.sv
// Directed bench for mipi_dsi_packet_parser with a burst-level reference parser.
module tb_mipi_dsi_packet_parser;
    import mipi_dsi_pkg::*;

`ifdef DSI_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif
    localparam logic [7:0] SYNC = 8'hB8;

    logic        byte_clk = 1'b0;
    logic        sys_rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        hdr_valid, hdr_long, hdr_ecc_err;
    logic [7:0]  hdr_di, pl_data;
    logic [15:0] hdr_wc;
    logic        pl_valid, pl_last, pkt_done, crc_err, trunc_err;

    mipi_dsi_packet_parser dut (
        .byte_clk    (byte_clk),
        .sys_rst     (sys_rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .hdr_valid   (hdr_valid),
        .hdr_di      (hdr_di),
        .hdr_wc      (hdr_wc),
        .hdr_long    (hdr_long),
        .hdr_ecc_err (hdr_ecc_err),
        .pl_valid    (pl_valid),
        .pl_data     (pl_data),
        .pl_last     (pl_last),
        .pkt_done    (pkt_done),
        .crc_err     (crc_err),
        .trunc_err   (trunc_err)
    );

    always #5 byte_clk = ~byte_clk;

    typedef struct packed {
        bit [31:0] cyc;
        bit        rst;
        bit        hv;
        bit [7:0]  di;
        bit [15:0] wc;
        bit        lng;
        bit        ecc_err;
        bit        pv;
        bit [7:0]  pdata;
        bit        pl;
        bit        done;
        bit        ce;
        bit        tr;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          chk_en = 1'b0;
    bit [7:0]    h_di;
    bit [15:0]   h_wc;
    bit          h_long;
    int          obs_hv = 0, obs_pv = 0, obs_pd = 0, obs_tr = 0;
    logic [7:0]  bq[$];
    logic [15:0] cur_crc;

    always @(posedge byte_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DSI ECC: each header bit contributes a fixed 6-bit syndrome column
    function automatic logic [5:0] ecc_code(input int i);
        case (i)
            0: return 6'h07;   1: return 6'h0B;   2: return 6'h0D;   3: return 6'h0E;
            4: return 6'h13;   5: return 6'h15;   6: return 6'h16;   7: return 6'h19;
            8: return 6'h1A;   9: return 6'h1C;  10: return 6'h23;  11: return 6'h25;
           12: return 6'h26;  13: return 6'h29;  14: return 6'h2A;  15: return 6'h2C;
           16: return 6'h31;  17: return 6'h32;  18: return 6'h34;  19: return 6'h38;
           20: return 6'h1F;  21: return 6'h2F;  22: return 6'h37;  default: return 6'h3B;
        endcase
    endfunction

    function automatic logic [7:0] m_ecc(input logic [23:0] h);
        logic [5:0] e = '0;
        for (int i = 0; i < 24; i++) if (h[i]) e ^= ecc_code(i);
        return {2'b00, e};
    endfunction

    function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    function automatic bit m_is_long(input logic [5:0] dt);
        return (dt[3:0] inside {4'h9, 4'hC, 4'hD, 4'hE}) || (dt == 6'h0B);
    endfunction

    always @(negedge byte_clk) begin : cmp
        exp_t e;
        if (chk_en) begin
            e = '0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
            if (hdr_valid === 1'b1) obs_hv++;
            if (pl_valid === 1'b1)  obs_pv++;
            if (pkt_done === 1'b1)  obs_pd++;
            if (trunc_err === 1'b1) obs_tr++;
            if (e.rst) begin
                check("reset_outputs", 64'({hdr_valid, hdr_di, hdr_wc, hdr_long, hdr_ecc_err, pl_valid,
                                            pl_data, pl_last, pkt_done, crc_err, trunc_err}), 64'(0));
                h_di = '0; h_wc = '0; h_long = 1'b0;
            end else begin
                check("pulses", 64'({hdr_valid, pl_valid, pl_last, pkt_done, trunc_err}),
                      64'({e.hv, e.pv, e.pl, e.done, e.tr}));
                if (e.hv) begin
                    h_di = e.di; h_wc = e.wc; h_long = e.lng;
                    check("hdr_ecc_err", 64'(hdr_ecc_err), 64'(e.ecc_err));
                end
                check("hdr_fields", 64'({hdr_di, hdr_wc, hdr_long}), 64'({h_di, h_wc, h_long}));
                if (e.pv)   check("pl_data", 64'(pl_data), 64'(e.pdata));
                if (e.done) check("crc_err", 64'(crc_err), 64'(e.ce));
            end
        end
    end

    task automatic b_start();
        bq.delete();
        bq.push_back(SYNC);
    endtask

    task automatic b_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc_xor);
        bq.push_back(di);
        bq.push_back(wc[7:0]);
        bq.push_back(wc[15:8]);
        bq.push_back(m_ecc({wc, di}) ^ ecc_xor);
        cur_crc = 16'hFFFF;
    endtask

    task automatic b_pl(input logic [7:0] d, input logic [7:0] flip);
        cur_crc = m_crc(cur_crc, d);
        bq.push_back(d ^ flip);
    endtask

    task automatic b_crc();
        bq.push_back(cur_crc[7:0]);
        bq.push_back(cur_crc[15:8]);
    endtask

    // Reference parse of a whole burst, then drive it byte by byte
    task automatic send_burst(input logic [7:0] b[$], input bit end_rst);
        exp_t        ev[];
        int          n, p, k;
        bit          trunc;
        logic [7:0]  di;
        logic [15:0] wc, crc;
        bit          lng;
        int unsigned st;
        n = b.size();
        trunc = 1'b0;
        @(posedge byte_clk); #1;
        st = cyc + 1;
        ev = new[n + 1];
        for (int i = 0; i <= n; i++) begin
            ev[i] = '0;
            ev[i].cyc = st + 32'(i);
        end
        p = 0;
        while (p < n && b[p] != SYNC) p++;
        if (p < n) begin
            p++;
            while (p < n) begin
                if (n - p < 4) begin trunc = 1'b1; break; end
                di = b[p];
                wc = {b[p+2], b[p+1]};
                lng = m_is_long(di[5:0]);
                k = p + 3;
                ev[k].hv = 1'b1; ev[k].di = di; ev[k].wc = wc; ev[k].lng = lng;
                ev[k].ecc_err = (b[p+3] != m_ecc({wc, di}));
                p += 4;
                if (!lng) begin ev[k].done = 1'b1; continue; end
                crc = 16'hFFFF;
                for (int j = 0; j < int'(wc) && p + j < n; j++) begin
                    ev[p+j].pv = 1'b1;
                    ev[p+j].pdata = b[p+j];
                    ev[p+j].pl = (j == int'(wc) - 1);
                    crc = m_crc(crc, b[p+j]);
                end
                if (n - p < int'(wc) + 2) begin trunc = 1'b1; break; end
                k = p + int'(wc) + 1;
                ev[k].done = 1'b1;
                ev[k].ce = CRC_ON && (crc != {b[k], b[k-1]});
                p += int'(wc) + 2;
            end
        end
        if (end_rst) ev[n].rst = 1'b1;
        else if (trunc) ev[n].tr = 1'b1;
        for (int i = 0; i <= n; i++) exp_q.push_back(ev[i]);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            @(posedge byte_clk); #1;
        end
        if (end_rst) begin
            sys_rst = 1'b1; in_valid = 1'b1; in_data = 8'h33;
            @(posedge byte_clk); #1;
            sys_rst = 1'b0;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge byte_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] c;
        int s_hv, s_pv, s_pd, s_tr;
        sys_rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge byte_clk);
        #1;
        exp_q.push_back('{cyc: cyc, rst: 1'b1, default: '0});
        chk_en = 1'b1;
        @(posedge byte_clk); #1;
        sys_rst = 1'b0;

        check("ecc_model_0x001105", 64'(m_ecc(24'h001105)), 64'(8'h36));
        check("ecc_model_0x000339", 64'(m_ecc(24'h000339)), 64'(8'h09));
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = m_crc(c, 8'(8'h31 + i));
        check("crc_model_123456789", 64'(c), 64'(16'h6F91));
        check("is_long_model", 64'({m_is_long(6'h39), m_is_long(6'h05), m_is_long(6'h0B), m_is_long(6'h21)}),
              64'(4'b1010));

        b_start(); b_hdr(8'(DT_DCS_SHORT_WR), 16'h0011, 8'h00);
        check("short_ecc_byte", 64'(bq[4]), 64'(8'h36));
        send_burst(bq, 1'b0);

        b_start(); b_hdr(8'(DT_DCS_LONG_WR), 16'd3, 8'h00);
        b_pl(8'h2C, 8'h00); b_pl(8'h01, 8'h00); b_pl(8'h02, 8'h00); b_crc();
        send_burst(bq, 1'b0);

        b_start(); b_hdr(8'(DT_DCS_LONG_WR), 16'd3, 8'h00);
        b_pl(8'h2C, 8'h00); b_pl(8'h01, 8'h00); b_pl(8'h02, 8'h01); b_crc();
        send_burst(bq, 1'b0);

        s_hv = obs_hv; s_pv = obs_pv; s_pd = obs_pd;
        b_start(); b_hdr(8'(DT_HSYNC_START), 16'h3412, 8'h00);
        b_hdr(8'(DT_RGB888), 16'd6, 8'h00);
        for (int i = 0; i < 6; i++) b_pl(8'(8'h10 + i), 8'h00);
        b_crc();
        send_burst(bq, 1'b0);
        check("b2b_hdr_count", 64'(obs_hv - s_hv), 64'(2));
        check("b2b_done_count", 64'(obs_pd - s_pd), 64'(2));
        check("b2b_pl_count", 64'(obs_pv - s_pv), 64'(6));

        b_start(); b_hdr(8'(DT_DCS_LONG_WR), 16'd2, 8'h01);
        b_pl(8'hA5, 8'h00); b_pl(8'h5A, 8'h00); b_crc();
        b_hdr(8'(DT_DCS_SHORT_WR), 16'h7701, 8'h80);
        send_burst(bq, 1'b0);

        s_tr = obs_tr;
        b_start(); b_hdr(8'(DT_DCS_LONG_WR), 16'd10, 8'h00);
        b_pl(8'h01, 8'h00); b_pl(8'h02, 8'h00);
        send_burst(bq, 1'b0);
        check("trunc_payload_count", 64'(obs_tr - s_tr), 64'(1));

        bq.delete(); bq.push_back(8'h00); bq.push_back(SYNC);
        b_hdr(8'(DT_DCS_SHORT_WR), 16'h0022, 8'h00);
        send_burst(bq, 1'b0);

        b_start(); bq.push_back(8'h05); bq.push_back(8'h11);
        send_burst(bq, 1'b0);

        b_start();
        send_burst(bq, 1'b0);

        b_start(); b_hdr(8'(DT_DCS_LONG_WR), 16'd1, 8'h00); b_pl(8'hAA, 8'h00);
        bq.push_back(cur_crc[7:0]);
        send_burst(bq, 1'b0);

        s_pv = obs_pv;
        b_start(); b_hdr(8'(DT_NULL), 16'd0, 8'h00); b_crc();
        check("wc0_crc_bytes", 64'({bq[6], bq[5]}), 64'(16'hFFFF));
        b_hdr(8'(DT_NULL), 16'd0, 8'h00); bq.push_back(8'h00); bq.push_back(8'h00);
        send_burst(bq, 1'b0);
        check("wc0_no_payload", 64'(obs_pv - s_pv), 64'(0));

        s_pd = obs_pd;
        b_start(); b_hdr(8'(DT_DCS_LONG_WR), 16'd4, 8'h00);
        b_pl(8'h11, 8'h00); b_pl(8'h22, 8'h00);
        send_burst(bq, 1'b1);
        check("reset_no_pkt_done", 64'(obs_pd - s_pd), 64'(0));

        b_start(); b_hdr(8'(DT_DCS_SHORT_WR), 16'h5A5A, 8'h00);
        send_burst(bq, 1'b0);

        repeat (4) @(posedge byte_clk);
        #1;
        check("expect_queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
